// File: rtl/ap_ctrl_txn_profiler.sv
// Handshake profiler for one ap_ctrl_hs block: measures latency and start-to-start
// interval per transaction and queues one record per transaction for a trace consumer.
//
// state  | meaning
// S_IDLE | waiting for ap_start; combinational done handled here
// S_BUSY | transaction in flight, lat_cnt running
// S_FROZEN | finish seen; taps ignored, FIFO still drains
module ap_ctrl_txn_profiler #(
  parameter int CNT_W      = 32,
  parameter int IDX_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             finish,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [CNT_W-1:0] rec_latency,
  output logic [CNT_W-1:0] rec_interval,
  output logic [IDX_W-1:0] rec_index,
  output logic [1:0]       rec_flags,
  output logic             busy,
  output logic             finished,
  output logic             overflow,
  output logic             proto_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FROZEN} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] lat_cnt, since_cnt, cur_int;
  logic             first_pend, cur_first;
  logic [IDX_W-1:0] idx_cnt;

  logic             start_evt, emit, emit_trunc;
  logic [CNT_W-1:0] emit_lat, emit_int;
  logic             emit_first;

  logic             pend_v;
  logic [CNT_W-1:0] pend_lat, pend_int;
  logic [IDX_W-1:0] pend_idx;
  logic [1:0]       pend_flags;

  logic [CNT_W-1:0] mem_lat [FIFO_DEPTH];
  logic [CNT_W-1:0] mem_int [FIFO_DEPTH];
  logic [IDX_W-1:0] mem_idx [FIFO_DEPTH];
  logic [1:0]       mem_flg [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             full, empty, push, pop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start_evt  = 1'b0;
    emit       = 1'b0;
    emit_trunc = 1'b0;
    emit_lat   = '0;
    case (state)
      S_IDLE: begin
        if (finish) begin
          state_nxt = S_FROZEN;
        end else if (ap_start) begin
          start_evt = 1'b1;
          if (ap_done) begin
            emit     = 1'b1;
            emit_lat = CNT_ONE;
          end else begin
            state_nxt = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (ap_done) begin
          emit      = 1'b1;
          emit_lat  = lat_cnt;
          state_nxt = finish ? S_FROZEN : S_IDLE;
        end else if (finish) begin
          emit       = 1'b1;
          emit_trunc = 1'b1;
          emit_lat   = lat_cnt;
          state_nxt  = S_FROZEN;
        end
      end
      default: state_nxt = state;
    endcase
  end

  // A same-cycle done in IDLE reports the live interval; BUSY reports the one latched at start.
  assign emit_int   = (state == S_IDLE) ? (first_pend ? '0 : since_cnt) : cur_int;
  assign emit_first = (state == S_IDLE) ? first_pend : cur_first;

  // lat_cnt holds the inclusive latency a done would report in the current cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lat_cnt    <= '0;
      since_cnt  <= '0;
      first_pend <= 1'b1;
      cur_int    <= '0;
      cur_first  <= 1'b0;
      idx_cnt    <= '0;
      pend_v     <= 1'b0;
      pend_lat   <= '0;
      pend_int   <= '0;
      pend_idx   <= '0;
      pend_flags <= '0;
    end else begin
      if (start_evt) begin
        since_cnt  <= CNT_ONE;
        lat_cnt    <= CNT_TWO;
        cur_int    <= first_pend ? '0 : since_cnt;
        cur_first  <= first_pend;
        first_pend <= 1'b0;
      end else begin
        if (since_cnt != CNT_MAX) since_cnt <= since_cnt + CNT_ONE;
        if (state == S_BUSY && lat_cnt != CNT_MAX) lat_cnt <= lat_cnt + CNT_ONE;
      end
      pend_v <= emit;
      if (emit) begin
        pend_lat   <= emit_lat;
        pend_int   <= emit_int;
        pend_idx   <= idx_cnt;
        pend_flags <= {emit_trunc, emit_first};
        idx_cnt    <= idx_cnt + IDX_W'(1);
      end
    end
  end

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign pop   = !empty && rec_ready;
  assign push  = pend_v && (!full || pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_lat[i] <= '0;
        mem_int[i] <= '0;
        mem_idx[i] <= '0;
        mem_flg[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_lat[wr_ptr] <= pend_lat;
        mem_int[wr_ptr] <= pend_int;
        mem_idx[wr_ptr] <= pend_idx;
        mem_flg[wr_ptr] <= pend_flags;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      if (pend_v && !push) overflow <= 1'b1;
      if (state == S_IDLE && !ap_start && (ap_done || ap_ready)) proto_err <= 1'b1;
    end
  end

  assign rec_valid    = !empty;
  assign rec_latency  = mem_lat[rd_ptr];
  assign rec_interval = mem_int[rd_ptr];
  assign rec_index    = mem_idx[rd_ptr];
  assign rec_flags    = mem_flg[rd_ptr];
  assign busy         = (state == S_BUSY);
  assign finished     = (state == S_FROZEN);

endmodule

// File: tb/tb_ap_ctrl_txn_profiler.sv
// Bench for ap_ctrl_txn_profiler: directed scenarios plus randomized taps against a
// timestamp-based transaction model with a bounded record queue.
module tb_ap_ctrl_txn_profiler;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        ap_start, ap_ready, ap_done, finish, rec_ready;
  logic        rec_valid, busy, finished, overflow, proto_err;
  logic [31:0] rec_latency, rec_interval;
  logic [15:0] rec_index;
  logic [1:0]  rec_flags;

  int n_chk  = 0;
  int n_pass = 0;

  ap_ctrl_txn_profiler #(.CNT_W(32), .IDX_W(16), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .finish(finish), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_latency(rec_latency), .rec_interval(rec_interval), .rec_index(rec_index),
    .rec_flags(rec_flags), .busy(busy), .finished(finished), .overflow(overflow),
    .proto_err(proto_err)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference model: transactions as start/done timestamps, records in a bounded queue.
  typedef struct {
    logic [31:0] lat;
    logic [31:0] intv;
    logic [15:0] idx;
    logic [1:0]  flags;
  } rec_t;

  rec_t        q[$];
  rec_t        pend;
  bit          pend_v, m_busy, m_frozen, m_have_prev, m_ovf, m_perr;
  int          m_cyc, m_start, m_prev_start;
  logic [31:0] m_int;
  bit          m_first;
  logic [15:0] m_idx;

  task automatic model_reset();
    q.delete();
    pend_v = 0; m_busy = 0; m_frozen = 0; m_have_prev = 0; m_ovf = 0; m_perr = 0;
    m_cyc = 0; m_start = 0; m_prev_start = 0; m_idx = '0; m_int = '0; m_first = 0;
  endtask

  task automatic model_emit(input int lat, input bit trunc);
    pend.lat   = 32'(lat);
    pend.intv  = m_int;
    pend.idx   = m_idx;
    pend.flags = {trunc, m_first};
    pend_v     = 1;
    m_idx++;
  endtask

  task automatic model_edge();
    bit had_pend;
    if (q.size() > 0 && rec_ready) void'(q.pop_front());
    had_pend = pend_v;
    pend_v   = 0;
    if (had_pend) begin
      if (q.size() < DEPTH) q.push_back(pend);
      else m_ovf = 1;
    end
    if (!m_frozen) begin
      if (!m_busy) begin
        if (!ap_start && (ap_done || ap_ready)) m_perr = 1;
        if (finish) m_frozen = 1;
        else if (ap_start) begin
          m_start      = m_cyc;
          m_first      = !m_have_prev;
          m_int        = m_have_prev ? 32'(m_cyc - m_prev_start) : 32'd0;
          m_have_prev  = 1;
          m_prev_start = m_cyc;
          if (ap_done) model_emit(1, 0);
          else m_busy = 1;
        end
      end else if (ap_done) begin
        model_emit(m_cyc - m_start + 1, 0);
        m_busy = 0;
        if (finish) m_frozen = 1;
      end else if (finish) begin
        model_emit(m_cyc - m_start + 1, 1);
        m_busy   = 0;
        m_frozen = 1;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
    m_cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    ap_start = 0; ap_ready = 0; ap_done = 0; finish = 0; rec_ready = 0;
    reset = 1;
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if ({rec_valid, busy, finished, overflow, proto_err, rec_latency, rec_interval, rec_index, rec_flags} !== '0)
      $display("FAIL reset_outputs: got valid=%b busy=%b fin=%b ovf=%b perr=%b lat=%0d int=%0d idx=%0d flg=%b, want all 0",
               rec_valid, busy, finished, overflow, proto_err, rec_latency, rec_interval, rec_index, rec_flags);
    else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    rec_ready = 1;
    run(10);
    ap_start = 1; tick();
    ap_start = 0;
    n_chk++;
    if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else n_pass++;
    run(3);
    ap_done = 1; tick();
    ap_done = 0;
    n_chk++;
    if (busy !== 1'b0) $display("FAIL single_idle: got busy=%b want 0", busy); else n_pass++;
    tick();
    n_chk++;
    if ({rec_valid, rec_latency, rec_interval, rec_index, rec_flags} !== {1'b1, 32'd5, 32'd0, 16'd0, 2'b01})
      $display("FAIL single_rec: got v=%b lat=%0d int=%0d idx=%0d flg=%b want v=1 lat=5 int=0 idx=0 flg=01",
               rec_valid, rec_latency, rec_interval, rec_index, rec_flags);
    else n_pass++;
    tick();
    n_chk++;
    if (rec_valid !== 1'b0) $display("FAIL single_pop: got valid=%b want 0", rec_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    run(10);
    ap_start = 1; run(5);
    ap_done = 1; tick();
    ap_done = 0; tick();
    ap_start = 0; run(4);
    ap_done = 1; tick();
    ap_done = 0; tick();
    n_chk++;
    if ({rec_valid, rec_latency, rec_interval, rec_index, rec_flags} !== {1'b1, 32'd6, 32'd0, 16'd0, 2'b01})
      $display("FAIL b2b_rec0: got v=%b lat=%0d int=%0d idx=%0d flg=%b want v=1 lat=6 int=0 idx=0 flg=01",
               rec_valid, rec_latency, rec_interval, rec_index, rec_flags);
    else n_pass++;
    rec_ready = 1; tick();
    n_chk++;
    if ({rec_valid, rec_latency, rec_interval, rec_index, rec_flags} !== {1'b1, 32'd6, 32'd6, 16'd1, 2'b00})
      $display("FAIL b2b_rec1: got v=%b lat=%0d int=%0d idx=%0d flg=%b want v=1 lat=6 int=6 idx=1 flg=00",
               rec_valid, rec_latency, rec_interval, rec_index, rec_flags);
    else n_pass++;
    tick();
    n_chk++;
    if (rec_valid !== 1'b0) $display("FAIL b2b_empty: got valid=%b want 0", rec_valid); else n_pass++;
  endtask

  task automatic test_comb_done();
    do_reset();
    rec_ready = 1;
    run(20);
    ap_start = 1; ap_done = 1; tick();
    ap_start = 0; ap_done = 0;
    n_chk++;
    if (busy !== 1'b0) $display("FAIL comb_busy: got %b want 0", busy); else n_pass++;
    tick();
    n_chk++;
    if ({rec_valid, busy, rec_latency, rec_index, rec_flags} !== {1'b1, 1'b0, 32'd1, 16'd0, 2'b01})
      $display("FAIL comb_rec: got v=%b busy=%b lat=%0d idx=%0d flg=%b want v=1 busy=0 lat=1 idx=0 flg=01",
               rec_valid, busy, rec_latency, rec_index, rec_flags);
    else n_pass++;
    tick();
  endtask

  task automatic test_overflow();
    do_reset();
    ap_start = 1; ap_done = 1; run(6);
    ap_start = 0; ap_done = 0; run(2);
    n_chk++;
    if ({overflow, rec_valid} !== 2'b11)
      $display("FAIL ovf_flag: got ovf=%b valid=%b want 1 1", overflow, rec_valid);
    else n_pass++;
    for (int s = 0; s < 3; s++) begin
      n_chk++;
      if ({rec_latency, rec_interval, rec_index, rec_flags} !== {32'd1, 32'd0, 16'd0, 2'b01})
        $display("FAIL ovf_stall%0d: got lat=%0d int=%0d idx=%0d flg=%b want lat=1 int=0 idx=0 flg=01",
                 s, rec_latency, rec_interval, rec_index, rec_flags);
      else n_pass++;
      tick();
    end
    rec_ready = 1;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if ({rec_valid, rec_index, rec_interval} !== {1'b1, 16'(i), (i == 0) ? 32'd0 : 32'd1})
        $display("FAIL ovf_drain%0d: got v=%b idx=%0d int=%0d want v=1 idx=%0d int=%0d",
                 i, rec_valid, rec_index, rec_interval, i, (i == 0) ? 0 : 1);
      else n_pass++;
      tick();
    end
    n_chk++;
    if ({rec_valid, overflow} !== 2'b01)
      $display("FAIL ovf_after: got valid=%b ovf=%b want 0 1", rec_valid, overflow);
    else n_pass++;
  endtask

  task automatic test_finish();
    do_reset();
    run(5);
    ap_start = 1; ap_done = 1; tick();
    ap_start = 0; ap_done = 0; run(24);
    ap_start = 1; tick();
    ap_start = 0; run(2);
    finish = 1; tick();
    n_chk++;
    if ({finished, busy} !== 2'b10) $display("FAIL fin_state: got fin=%b busy=%b want 1 0", finished, busy); else n_pass++;
    tick();
    finish = 0;
    rec_ready = 1; tick();
    n_chk++;
    if ({rec_valid, rec_latency, rec_interval, rec_index, rec_flags} !== {1'b1, 32'd4, 32'd25, 16'd1, 2'b10})
      $display("FAIL fin_rec: got v=%b lat=%0d int=%0d idx=%0d flg=%b want v=1 lat=4 int=25 idx=1 flg=10",
               rec_valid, rec_latency, rec_interval, rec_index, rec_flags);
    else n_pass++;
    tick();
    for (int i = 0; i < 4; i++) begin
      ap_start = 1; ap_done = i[0]; tick();
      ap_start = 0; ap_done = 1; tick();
      ap_done = 0;
    end
    run(3);
    n_chk++;
    if ({rec_valid, finished, proto_err} !== 3'b010)
      $display("FAIL fin_frozen: got v=%b fin=%b perr=%b want 0 1 0", rec_valid, finished, proto_err);
    else n_pass++;
  endtask

  task automatic test_protocol();
    do_reset();
    ap_done = 1; tick();
    ap_done = 0;
    n_chk++;
    if (proto_err !== 1'b1) $display("FAIL perr_done: got %b want 1", proto_err); else n_pass++;
    run(3);
    n_chk++;
    if (proto_err !== 1'b1) $display("FAIL perr_sticky: got %b want 1", proto_err); else n_pass++;
    do_reset();
    ap_ready = 1; tick();
    ap_ready = 0;
    n_chk++;
    if (proto_err !== 1'b1) $display("FAIL perr_ready: got %b want 1", proto_err); else n_pass++;
    do_reset();
    ap_start = 1; ap_ready = 1; ap_done = 1; tick();
    ap_ready = 0; ap_done = 0; tick();
    ap_start = 0; tick();
    n_chk++;
    if ({proto_err, rec_valid, busy} !== 3'b011)
      $display("FAIL perr_legal: got perr=%b v=%b busy=%b want 0 1 1", proto_err, rec_valid, busy);
    else n_pass++;
    #2 reset = 1;
    #1;
    n_chk++;
    if ({rec_valid, busy, finished, overflow, proto_err, rec_latency, rec_interval, rec_index, rec_flags} !== '0)
      $display("FAIL reset_midbusy: got v=%b busy=%b fin=%b ovf=%b perr=%b lat=%0d idx=%0d want all 0",
               rec_valid, busy, finished, overflow, proto_err, rec_latency, rec_index);
    else n_pass++;
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 0;
    run(3);
    n_chk++;
    if ({rec_valid, busy} !== 2'b00) $display("FAIL reset_norec: got v=%b busy=%b want 0 0", rec_valid, busy); else n_pass++;
  endtask

  task automatic test_random(input int ready_pct, input int ncyc);
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      ap_start  = ($urandom_range(99) < 35);
      ap_done   = ($urandom_range(99) < 30);
      ap_ready  = ap_start ? ($urandom_range(1) == 1) : ($urandom_range(99) < 2);
      rec_ready = ($urandom_range(99) < ready_pct);
      finish    = (c >= ncyc - 40);
      tick();
      n_chk++;
      if ({rec_valid, busy, finished, overflow, proto_err} !== {q.size() != 0, m_busy, m_frozen, m_ovf, m_perr})
        $display("FAIL rand_status c=%0d: got v=%b b=%b f=%b o=%b p=%b want v=%b b=%b f=%b o=%b p=%b", c,
                 rec_valid, busy, finished, overflow, proto_err, q.size() != 0, m_busy, m_frozen, m_ovf, m_perr);
      else n_pass++;
      if (q.size() != 0) begin
        n_chk++;
        if ({rec_latency, rec_interval, rec_index, rec_flags} !== {q[0].lat, q[0].intv, q[0].idx, q[0].flags})
          $display("FAIL rand_rec c=%0d: got lat=%0d int=%0d idx=%0d flg=%b want lat=%0d int=%0d idx=%0d flg=%b", c,
                   rec_latency, rec_interval, rec_index, rec_flags, q[0].lat, q[0].intv, q[0].idx, q[0].flags);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_comb_done();
    test_overflow();
    test_finish();
    test_protocol();
    test_random(70, 400);
    test_random(20, 400);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
